// File: rtl/alu_operand_issue_if.sv
// ----------------------------------------------------------------------------
// alu_operand_issue_if
// Decode-to-issue handshake bundle. Decode presents one instruction per cycle
// with id_valid. The issue stage answers with id_ready in the same cycle.
//
// Signals:
//   id_valid                  decode holds a valid instruction
//   id_ready                  issue stage accepts it this cycle
//   id_rs1_addr/id_rs2_addr   source register indices
//   id_rs1_data/id_rs2_data   register-file read data
//   id_imm, id_pc             sign-extended immediate, instruction PC
//   id_src_a                  operand A select (00=rs1, 01=pc, 1x=zero)
//   id_src_b                  operand B select (0=rs2, 1=imm)
//   id_alu_op                 ALU opcode
//   id_rd_addr                destination register
//   id_reg_write/_mem_read/_mem_write   control bits
//
// Modports:
//   master  decode side (drives the instruction, samples id_ready)
//   slave   issue side (samples the instruction, drives id_ready)
// ----------------------------------------------------------------------------
interface alu_operand_issue_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      id_valid;
    logic                      id_ready;
    logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
    logic [DATA_WIDTH-1:0]     id_rs1_data;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [DATA_WIDTH-1:0]     id_pc;
    logic [1:0]                id_src_a;
    logic                      id_src_b;
    logic [3:0]                id_alu_op;
    logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      id_mem_write;

    modport master (
        output id_valid,
        output id_rs1_addr,
        output id_rs2_addr,
        output id_rs1_data,
        output id_rs2_data,
        output id_imm,
        output id_pc,
        output id_src_a,
        output id_src_b,
        output id_alu_op,
        output id_rd_addr,
        output id_reg_write,
        output id_mem_read,
        output id_mem_write,
        input  id_ready
    );

    modport slave (
        input  id_valid,
        input  id_rs1_addr,
        input  id_rs2_addr,
        input  id_rs1_data,
        input  id_rs2_data,
        input  id_imm,
        input  id_pc,
        input  id_src_a,
        input  id_src_b,
        input  id_alu_op,
        input  id_rd_addr,
        input  id_reg_write,
        input  id_mem_read,
        input  id_mem_write,
        output id_ready
    );
endinterface

// File: rtl/alu_operand_issue.sv
// ----------------------------------------------------------------------------
// alu_operand_issue
// ID/EX stage register feeding the ALU. Picks operand sources, resolves RAW
// hazards by forwarding from EX, MEM and WB, inserts a one-cycle bubble on a
// load-use hazard, holds under EX backpressure and clears on flush.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   id                decode handshake bundle (slave side)
//   ex_ready          EX can accept/advance its occupant
//   ex_result         combinational ALU result of the current occupant
//   mem_fwd_*         MEM-stage forward (valid, rd, data)
//   wb_fwd_*          WB-stage forward (valid, rd, data)
//   flush             kill the occupant and the decode instruction
//   ex_valid          occupant valid
//   ex_a, ex_b        ALU operands
//   ex_alu_op         ALU opcode
//   ex_store_data     forwarded rs2 value for stores
//   ex_rd_addr        occupant destination register
//   ex_reg_write/_mem_read/_mem_write   occupant control bits
//   stall_cnt         saturating count of load-use stall cycles
// ----------------------------------------------------------------------------
module alu_operand_issue #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_operand_issue_if.slave        id,
    input  logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     ex_result,
    input  logic                      mem_fwd_valid,
    input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
    input  logic                      wb_fwd_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     wb_fwd_data,
    input  logic                      flush,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     ex_a,
    output logic [DATA_WIDTH-1:0]     ex_b,
    output logic [3:0]                ex_alu_op,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    logic                  ex_fwd_ok;
    logic                  rs1_is_x0;
    logic                  rs2_is_x0;
    logic                  rs1_hit_ex;
    logic                  rs1_hit_mem;
    logic                  rs1_hit_wb;
    logic                  rs2_hit_ex;
    logic                  rs2_hit_mem;
    logic                  rs2_hit_wb;
    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;
    logic [DATA_WIDTH-1:0] opnd_a;
    logic [DATA_WIDTH-1:0] opnd_b;
    logic                  hazard;
    logic                  adv;
    logic                  accept;
    logic                  stall_event;

    // A load occupant has no result yet, so it never forwards from EX;
    // that case is covered by the load-use bubble instead.
    assign ex_fwd_ok   = ex_valid & ex_reg_write & ~ex_mem_read;

    assign rs1_is_x0   = (id.id_rs1_addr == '0);
    assign rs2_is_x0   = (id.id_rs2_addr == '0);

    assign rs1_hit_ex  = ex_fwd_ok     & (ex_rd_addr == id.id_rs1_addr);
    assign rs1_hit_mem = mem_fwd_valid & (mem_fwd_rd == id.id_rs1_addr);
    assign rs1_hit_wb  = wb_fwd_valid  & (wb_fwd_rd  == id.id_rs1_addr);
    assign rs2_hit_ex  = ex_fwd_ok     & (ex_rd_addr == id.id_rs2_addr);
    assign rs2_hit_mem = mem_fwd_valid & (mem_fwd_rd == id.id_rs2_addr);
    assign rs2_hit_wb  = wb_fwd_valid  & (wb_fwd_rd  == id.id_rs2_addr);

    // Youngest producer wins: EX, then MEM, then WB, then the register file.
    always_comb begin
        rs1_fwd = id.id_rs1_data;
        if (rs1_is_x0) begin
            rs1_fwd = '0;
        end else if (rs1_hit_ex) begin
            rs1_fwd = ex_result;
        end else if (rs1_hit_mem) begin
            rs1_fwd = mem_fwd_data;
        end else if (rs1_hit_wb) begin
            rs1_fwd = wb_fwd_data;
        end
    end

    always_comb begin
        rs2_fwd = id.id_rs2_data;
        if (rs2_is_x0) begin
            rs2_fwd = '0;
        end else if (rs2_hit_ex) begin
            rs2_fwd = ex_result;
        end else if (rs2_hit_mem) begin
            rs2_fwd = mem_fwd_data;
        end else if (rs2_hit_wb) begin
            rs2_fwd = wb_fwd_data;
        end
    end

    always_comb begin
        opnd_a = '0;
        case (id.id_src_a)
            2'b00:   opnd_a = rs1_fwd;
            2'b01:   opnd_a = id.id_pc;
            default: opnd_a = '0;
        endcase
    end

    assign opnd_b = id.id_src_b ? id.id_imm : rs2_fwd;

    // Checked against both sources whatever the operand selects say; a
    // spurious stall costs one cycle, a missed one corrupts data.
    assign hazard = id.id_valid & ex_valid & ex_mem_read & (ex_rd_addr != '0)
                  & ((ex_rd_addr == id.id_rs1_addr) | (ex_rd_addr == id.id_rs2_addr));

    assign adv         = ~ex_valid | ex_ready;
    assign id.id_ready = rst_n & adv & ~hazard & ~flush;
    assign accept      = adv & id.id_valid & id.id_ready;
    assign stall_event = hazard & adv & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_alu_op     <= '0;
            ex_store_data <= '0;
            ex_rd_addr    <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
        end else if (flush) begin
            // Data fields keep their last values; only validity and side
            // effects are killed.
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (accept) begin
            ex_valid      <= 1'b1;
            ex_a          <= opnd_a;
            ex_b          <= opnd_b;
            ex_alu_op     <= id.id_alu_op;
            ex_store_data <= rs2_fwd;
            ex_rd_addr    <= id.id_rd_addr;
            ex_reg_write  <= id.id_reg_write;
            ex_mem_read   <= id.id_mem_read;
            ex_mem_write  <= id.id_mem_write;
        end else if (adv) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end
        // !adv: everything holds, including the already-captured operands.
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_event && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_alu_operand_issue.sv
module tb_alu_operand_issue;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_ready;
    logic [DW-1:0] ex_result;
    logic          mem_fwd_valid;
    logic [AW-1:0] mem_fwd_rd;
    logic [DW-1:0] mem_fwd_data;
    logic          wb_fwd_valid;
    logic [AW-1:0] wb_fwd_rd;
    logic [DW-1:0] wb_fwd_data;
    logic          flush;
    logic          ex_valid;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [3:0]    ex_alu_op;
    logic [DW-1:0] ex_store_data;
    logic [AW-1:0] ex_rd_addr;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    alu_operand_issue_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dif ();

    alu_operand_issue #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id            (dif),
        .ex_ready      (ex_ready),
        .ex_result     (ex_result),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_fwd_valid  (wb_fwd_valid),
        .wb_fwd_rd     (wb_fwd_rd),
        .wb_fwd_data   (wb_fwd_data),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_alu_op     (ex_alu_op),
        .ex_store_data (ex_store_data),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .stall_cnt     (stall_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: what the EX slot should contain.
    typedef struct {
        bit            valid;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] sd;
        logic [3:0]    op;
        logic [AW-1:0] rd;
        bit            rw;
        bit            mr;
        bit            mw;
    } occ_t;

    occ_t        m;
    int unsigned m_cnt;

    function automatic logic [DW-1:0] ref_fwd(input logic [AW-1:0] r, input logic [DW-1:0] rf);
        bit            vs[3];
        logic [AW-1:0] rds[3];
        logic [DW-1:0] ds[3];
        if (r == 0) return '0;
        vs[0] = m.valid && m.rw && !m.mr; rds[0] = m.rd;       ds[0] = ex_result;
        vs[1] = mem_fwd_valid;            rds[1] = mem_fwd_rd; ds[1] = mem_fwd_data;
        vs[2] = wb_fwd_valid;             rds[2] = wb_fwd_rd;  ds[2] = wb_fwd_data;
        for (int i = 0; i < 3; i++)
            if (vs[i] && rds[i] == r) return ds[i];
        return rf;
    endfunction

    task automatic idle();
        dif.id_valid = 0; dif.id_rs1_addr = 0; dif.id_rs2_addr = 0;
        dif.id_rs1_data = 0; dif.id_rs2_data = 0; dif.id_imm = 0; dif.id_pc = 0;
        dif.id_src_a = 0; dif.id_src_b = 0; dif.id_alu_op = 0; dif.id_rd_addr = 0;
        dif.id_reg_write = 0; dif.id_mem_read = 0; dif.id_mem_write = 0;
        ex_ready = 1; ex_result = 0; flush = 0;
        mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    endtask

    task automatic instr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                         input logic [1:0] sa, input logic sb, input logic [3:0] op,
                         input logic rw, input logic mr, input logic mw);
        dif.id_valid = 1; dif.id_rs1_addr = rs1; dif.id_rs2_addr = rs2; dif.id_rd_addr = rd;
        dif.id_rs1_data = d1; dif.id_rs2_data = d2; dif.id_imm = imm; dif.id_pc = 32'h100;
        dif.id_src_a = sa; dif.id_src_b = sb; dif.id_alu_op = op;
        dif.id_reg_write = rw; dif.id_mem_read = mr; dif.id_mem_write = mw;
    endtask

    // Called just after a negedge with inputs applied: checks id_ready,
    // predicts the slot after the next posedge, then checks the outputs.
    task automatic step();
        occ_t nx;
        bit   hz, adv, rdy;
        #1;
        hz  = dif.id_valid && m.valid && m.mr && m.rd != 0 &&
              (m.rd == dif.id_rs1_addr || m.rd == dif.id_rs2_addr);
        adv = !m.valid || ex_ready;
        rdy = rst_n && adv && !hz && !flush;
        check("id_ready", dif.id_ready, rdy);
        nx = m;
        if (!rst_n) begin
            nx = '{default: '0};
        end else if (flush) begin
            nx.valid = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0;
        end else if (adv && dif.id_valid && rdy) begin
            nx.valid = 1;
            nx.sd = ref_fwd(dif.id_rs2_addr, dif.id_rs2_data);
            nx.a  = (dif.id_src_a == 0) ? ref_fwd(dif.id_rs1_addr, dif.id_rs1_data) :
                    (dif.id_src_a == 1) ? dif.id_pc : '0;
            nx.b  = dif.id_src_b ? dif.id_imm : nx.sd;
            nx.op = dif.id_alu_op; nx.rd = dif.id_rd_addr;
            nx.rw = dif.id_reg_write; nx.mr = dif.id_mem_read; nx.mw = dif.id_mem_write;
        end else if (adv) begin
            nx.valid = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0;
        end
        if (!rst_n) m_cnt = 0;
        else if (hz && adv && !flush && m_cnt < (1 << CW) - 1) m_cnt++;
        @(posedge clk);
        m = nx;
        #1;
        check("ex_valid", ex_valid, m.valid);
        check("ex_reg_write", ex_reg_write, m.rw);
        check("ex_mem_read", ex_mem_read, m.mr);
        check("ex_mem_write", ex_mem_write, m.mw);
        check("stall_cnt", stall_cnt, m_cnt);
        if (m.valid) begin
            check("ex_a", ex_a, m.a);
            check("ex_b", ex_b, m.b);
            check("ex_store_data", ex_store_data, m.sd);
            check("ex_alu_op", ex_alu_op, m.op);
            check("ex_rd_addr", ex_rd_addr, m.rd);
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, ex_valid, 0);
        check({tag, "_a"}, ex_a, 0);
        check({tag, "_b"}, ex_b, 0);
        check({tag, "_op"}, ex_alu_op, 0);
        check({tag, "_sd"}, ex_store_data, 0);
        check({tag, "_rd"}, ex_rd_addr, 0);
        check({tag, "_ctl"}, {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        check({tag, "_cnt"}, stall_cnt, 0);
    endtask

    initial begin
        m = '{default: '0};
        m_cnt = 0;
        idle();
        rst_n = 0;
        @(negedge clk);
        step();
        step();
        check_all_zero("reset");

        // 1: add x3,x1,x2
        rst_n = 1;
        instr(1, 2, 3, 5, 7, 0, 0, 0, 4'h0, 1, 0, 0);
        step();
        check("t1_valid", ex_valid, 1);
        check("t1_a", ex_a, 5);
        check("t1_b", ex_b, 7);
        check("t1_rd", ex_rd_addr, 3);

        // 2: sub x4,x3,x3 with EX result and a stale MEM forward for x3
        instr(3, 3, 4, 1, 2, 0, 0, 0, 4'h1, 1, 0, 0);
        ex_result = 32'h10; mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h99;
        step();
        check("t2_a", ex_a, 32'h10);
        check("t2_b", ex_b, 32'h10);
        mem_fwd_valid = 0;

        // 3: lw x5 then addi x6,x5,1
        instr(1, 0, 5, 32'h40, 0, 8, 0, 1, 4'h0, 1, 1, 0);
        step();
        instr(5, 0, 6, 32'hDEAD, 0, 1, 0, 1, 4'h0, 1, 0, 0);
        step();
        check("t3_bubble", ex_valid, 0);
        check("t3_cnt", stall_cnt, 1);
        mem_fwd_valid = 1; mem_fwd_rd = 5; mem_fwd_data = 32'h2A;
        step();
        check("t3_a", ex_a, 32'h2A);
        check("t3_b", ex_b, 1);

        // 4: backpressure with changing forwards
        idle();
        instr(6, 6, 7, 3, 3, 0, 0, 0, 4'h2, 1, 0, 0);
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            ex_result = $urandom; mem_fwd_valid = 1; mem_fwd_rd = 6; mem_fwd_data = $urandom;
            step();
            check("t4_hold_a", ex_a, 32'h2A);
            check("t4_hold_b", ex_b, 1);
        end

        // 5: x0 handling and LUI
        idle();
        instr(0, 0, 8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 1, 0, 0);
        wb_fwd_valid = 1; wb_fwd_rd = 0; wb_fwd_data = 32'h55;
        step();
        check("t5_x0_a", ex_a, 0);
        check("t5_x0_sd", ex_store_data, 0);
        idle();
        instr(7, 0, 9, 3, 0, 32'h12345000, 2, 1, 4'h0, 1, 0, 0);
        step();
        check("t5_lui_a", ex_a, 0);
        check("t5_lui_b", ex_b, 32'h12345000);

        // 6: flush during a hazard, then reset during a stall
        idle();
        instr(1, 0, 5, 0, 0, 0, 0, 1, 4'h0, 1, 1, 0);
        step();
        instr(0, 5, 6, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
        flush = 1;
        step();
        check("t6_flush_valid", ex_valid, 0);
        check("t6_flush_cnt", stall_cnt, 1);
        flush = 0;
        instr(1, 0, 5, 0, 0, 0, 0, 1, 4'h0, 1, 1, 0);
        step();
        instr(5, 0, 6, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
        rst_n = 0;
        step();
        check_all_zero("t6_rst");
        rst_n = 1;

        // Saturation of the stall counter.
        for (int i = 0; i < 18; i++) begin
            idle();
            instr(1, 0, 5, 0, 0, 0, 0, 1, 4'h0, 1, 1, 0);
            step();
            instr(2, 5, 6, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
            step();
        end
        check("sat_cnt", stall_cnt, 4'hF);

        // Randomised traffic with a small register range so hazards and
        // forwards collide often.
        for (int i = 0; i < 600; i++) begin
            rst_n         = ($urandom_range(0, 63) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            ex_ready      = ($urandom_range(0, 3) != 0);
            ex_result     = $urandom;
            mem_fwd_valid = $urandom_range(0, 1);
            mem_fwd_rd    = AW'($urandom_range(0, 3));
            mem_fwd_data  = $urandom;
            wb_fwd_valid  = $urandom_range(0, 1);
            wb_fwd_rd     = AW'($urandom_range(0, 3));
            wb_fwd_data   = $urandom;
            instr(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            dif.id_valid = ($urandom_range(0, 3) != 0);
            dif.id_pc    = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
